silife_frame_scheduler: RTL

//  Paces the Life grid engine against the VGA frame. Issues one generation step every

---
 rtl/silife_pkg.sv | 21 ++
 rtl/silife_edge_detect.sv | 24 ++
 rtl/silife_frame_scheduler.sv | 115 +++++++++++
 3 files changed

// File: rtl/silife_pkg.sv
// Shared types and helpers for the Life frame scheduler.
package silife_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } sched_state_t;

  localparam int FRAME_BITS = 8;

  // Active level of vsync for a given polarity setting (0 = active-low pulse).
  function automatic logic vsync_active_level(input int pol);
    return (pol != 0);
  endfunction

  // An interval of 0 frames behaves as 1 frame per generation.
  function automatic logic [FRAME_BITS-1:0] interval_limit(input logic [FRAME_BITS-1:0] interval);
    return (interval == '0) ? FRAME_BITS'(1) : interval;
  endfunction

endpackage

// File: rtl/silife_edge_detect.sv
// Registered detector: one-cycle pulse when a level goes from inactive to active.
module silife_edge_detect #(
  parameter logic ACTIVE_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic level_q;

  // Reset loads the inactive level so a held-active input reads as a fresh edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= ~ACTIVE_LEVEL;
      rise    <= 1'b0;
    end else begin
      level_q <= level;
      rise    <= (level == ACTIVE_LEVEL) && (level_q != ACTIVE_LEVEL);
    end
  end

endmodule

// File: rtl/silife_frame_scheduler.sv
// Paces Life generations against the VGA frame and arbitrates the cell row-select bus.
// state   | meaning
// ST_IDLE | no generation in flight; waits for a slot or a pending request at vsync
// ST_BUSY | generation in flight; engine may use the row bus outside VGA cell display
module silife_frame_scheduler
  import silife_pkg::*;
#(
  parameter  int HEIGHT    = 32,
  parameter  int VSYNC_POL = 0,
  parameter  int GEN_BITS  = 16,
  localparam int ROW_BITS  = $clog2(HEIGHT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_vsync,
  input  logic                i_vga_active,
  input  logic [ROW_BITS-1:0] i_vga_row,
  input  logic                i_run,
  input  logic                i_step,
  input  logic [7:0]          i_interval,
  input  logic                i_clear,
  input  logic                i_eng_req,
  input  logic [ROW_BITS-1:0] i_eng_row,
  input  logic                i_step_done,
  output logic                o_step,
  output logic                o_eng_gnt,
  output logic [ROW_BITS-1:0] o_row_select,
  output logic                o_busy,
  output logic [GEN_BITS-1:0] o_generation,
  output logic                o_overrun
);

  logic                  frame_tick;
  logic [FRAME_BITS-1:0] frame_cnt;
  logic [FRAME_BITS-1:0] frame_lim;
  logic                  slot;
  logic                  pending;
  logic                  fire;
  sched_state_t          state;

  silife_edge_detect #(
    .ACTIVE_LEVEL(vsync_active_level(VSYNC_POL))
  ) u_vsync_edge (
    .clk  (clk),
    .reset(reset),
    .level(i_vsync),
    .rise (frame_tick)
  );

  // A compare of >= lets a shrunk interval wrap on the very next frame.
  assign frame_lim = interval_limit(i_interval);
  assign slot      = i_run & frame_tick & (frame_cnt >= (frame_lim - FRAME_BITS'(1)));
  assign fire      = (state == ST_IDLE) & (slot | (pending & frame_tick));

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (!i_run) begin
      frame_cnt <= '0;
    end else if (frame_tick) begin
      frame_cnt <= slot ? '0 : frame_cnt + FRAME_BITS'(1);
    end
  end

  // One outstanding manual request; extra pulses are absorbed.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
    end else if (fire) begin
      pending <= 1'b0;
    end else if (i_step && !i_run) begin
      pending <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      o_step       <= 1'b0;
      o_busy       <= 1'b0;
      o_generation <= '0;
      o_overrun    <= 1'b0;
    end else begin
      o_step <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fire) begin
            o_step <= 1'b1;
            o_busy <= 1'b1;
            state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (i_step_done) begin
            o_busy <= 1'b0;
            state  <= ST_IDLE;
          end
        end
      endcase

      if (i_clear) begin
        o_generation <= '0;
        o_overrun    <= 1'b0;
      end else if (state == ST_BUSY) begin
        if (i_step_done) o_generation <= o_generation + GEN_BITS'(1);
        if (slot)        o_overrun    <= 1'b1;
      end
    end
  end

  // Combinational so VGA wins the bus on the same cycle it enters the cell area.
  assign o_eng_gnt    = o_busy & i_eng_req & ~i_vga_active;
  assign o_row_select = o_eng_gnt ? i_eng_row : (i_vga_active ? i_vga_row : '0);

endmodule
